// File: rtl/traffic_phase_timer_if.sv
// Signal bundle between the phase timer and the traffic light sequencer.
// The sequencer side drives the sensor and the current light; the timer side answers with step and status.
interface traffic_phase_timer_if;
    logic       sensor_in;
    logic [3:0] light;
    logic       step;
    logic       req_pending;
    logic       sensor_db;
    logic       phase_err;

    modport master (
        output sensor_in,
        output light,
        input  step,
        input  req_pending,
        input  sensor_db,
        input  phase_err
    );

    modport slave (
        input  sensor_in,
        input  light,
        output step,
        output req_pending,
        output sensor_db,
        output phase_err
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// Sensor synchronizer/debouncer, request latch and per-phase dwell timer
// that pulses step once per phase for the traffic light sequencer.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_COUNT | dwell running; fires step when cnt reaches dwell-1
//   ST_ACK   | step issued; wait for the sequencer to change light
module traffic_phase_timer #(
    parameter int DEB_CYCLES    = 4,
    parameter int BLACK_CYCLES  = 2,
    parameter int RED_CYCLES    = 8,
    parameter int GREEN_CYCLES  = 10,
    parameter int YELLOW_CYCLES = 3,
    parameter int CW            = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_phase_timer_if.slave  bus
);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_ACK   = 1'b1
    } state_t;

    localparam logic [3:0] L_BLACK  = 4'b1000;
    localparam logic [3:0] L_RED    = 4'b0100;
    localparam logic [3:0] L_GREEN  = 4'b0010;
    localparam logic [3:0] L_YELLOW = 4'b0001;

    localparam logic [7:0]    DEB_LIM   = 8'(DEB_CYCLES);
    localparam logic [CW-1:0] BLACK_M1  = CW'(BLACK_CYCLES - 1);
    localparam logic [CW-1:0] RED_M1    = CW'(RED_CYCLES - 1);
    localparam logic [CW-1:0] GREEN_M1  = CW'(GREEN_CYCLES - 1);
    localparam logic [CW-1:0] YELLOW_M1 = CW'(YELLOW_CYCLES - 1);

    logic          sync1;
    logic          s_sync;
    logic [7:0]    deb_cnt;
    logic [7:0]    deb_next;
    logic          sensor_db;
    logic          db_prev;
    logic          req_pending;
    logic          req_set;
    logic          req_clr;

    logic [3:0]    prev_light;
    logic [CW-1:0] cnt;
    logic [CW-1:0] dwell_m1;
    state_t        state;
    logic          step;
    logic          phase_err;

    logic          light_valid;
    logic          phase_change;
    logic          fire;
    logic          step_load;

    // Two-flop synchronizer for the asynchronous sensor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            s_sync <= 1'b0;
        end else begin
            sync1  <= bus.sensor_in;
            s_sync <= sync1;
        end
    end

    assign deb_next = deb_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt   <= 8'd0;
            sensor_db <= 1'b0;
        end else if (s_sync == sensor_db) begin
            deb_cnt <= 8'd0;
        end else if (deb_next == DEB_LIM) begin
            sensor_db <= s_sync;
            deb_cnt   <= 8'd0;
        end else begin
            deb_cnt <= deb_next;
        end
    end

    always_comb begin
        light_valid  = (bus.light != 4'b0000) &&
                       ((bus.light & (bus.light - 4'd1)) == 4'b0000);
        phase_change = (bus.light != prev_light);
        fire         = (bus.light != L_RED) || req_pending;
        dwell_m1     = BLACK_M1;
        case (bus.light)
            L_BLACK:  dwell_m1 = BLACK_M1;
            L_RED:    dwell_m1 = RED_M1;
            L_GREEN:  dwell_m1 = GREEN_M1;
            L_YELLOW: dwell_m1 = YELLOW_M1;
            default:  dwell_m1 = BLACK_M1;
        endcase
        step_load = light_valid && !phase_change && (state == ST_COUNT) &&
                    (cnt == dwell_m1) && fire;
    end

    // A fresh rise of sensor_db beats a red step clearing the same request.
    assign req_set = sensor_db && !db_prev;
    assign req_clr = step_load && (bus.light == L_RED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev     <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            db_prev <= sensor_db;
            if (req_set) begin
                req_pending <= 1'b1;
            end else if (req_clr) begin
                req_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_light <= 4'b0000;
            cnt        <= '0;
            state      <= ST_COUNT;
            step       <= 1'b0;
            phase_err  <= 1'b0;
        end else begin
            prev_light <= bus.light;
            step       <= 1'b0;
            if (!light_valid) begin
                phase_err <= 1'b1;
                cnt       <= '0;
                state     <= ST_COUNT;
            end else begin
                phase_err <= 1'b0;
                if (phase_change) begin
                    cnt   <= '0;
                    state <= ST_COUNT;
                end else begin
                    if (cnt < dwell_m1) begin
                        cnt <= cnt + 1'b1;
                    end
                    case (state)
                        ST_COUNT: begin
                            if (step_load) begin
                                step  <= 1'b1;
                                state <= ST_ACK;
                            end
                        end
                        ST_ACK: begin
                            state <= ST_ACK;
                        end
                        default: begin
                            state <= ST_COUNT;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.step        = step;
    assign bus.req_pending = req_pending;
    assign bus.sensor_db   = sensor_db;
    assign bus.phase_err   = phase_err;

endmodule
